// File: rtl/float_gt_compare.sv
// Registered IEEE-754 "float1 > float2" comparator, one-cycle latency, full throughput.
// Optional `unordered` output enabled by defining FLOAT_GT_UNORDERED_EN.
module float_gt_compare #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [EXP_W+MAN_W:0]     float1,
  input  logic [EXP_W+MAN_W:0]     float2,
  output logic                     out_valid,
`ifdef FLOAT_GT_UNORDERED_EN
  output logic                     unordered,
`endif
  output logic                     gt
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W = EXP_W + MAN_W;

  logic             sign1, sign2;
  logic [MAG_W-1:0] mag1, mag2;
  logic             nan1, nan2;
  logic             any_nan;
  logic             gt_next;

  assign sign1 = float1[W-1];
  assign sign2 = float2[W-1];
  assign mag1  = float1[MAG_W-1:0];
  assign mag2  = float2[MAG_W-1:0];
  assign nan1  = (&float1[W-2:MAN_W]) && (|float1[MAN_W-1:0]);
  assign nan2  = (&float2[W-2:MAN_W]) && (|float2[MAN_W-1:0]);
  assign any_nan = nan1 || nan2;

  // Sign-magnitude ordering: the magnitude field orders subnormals and infinities directly.
  always_comb begin
    gt_next = 1'b0;
    if (any_nan) begin
      gt_next = 1'b0;
    end else if ((mag1 == '0) && (mag2 == '0)) begin
      gt_next = 1'b0;
    end else if (sign1 != sign2) begin
      gt_next = ~sign1;
    end else if (!sign1) begin
      gt_next = (mag1 > mag2);
    end else begin
      gt_next = (mag1 < mag2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      gt        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt <= gt_next;
      end
    end
  end

`ifdef FLOAT_GT_UNORDERED_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unordered <= 1'b0;
    end else if (in_valid) begin
      unordered <= any_nan;
    end
  end
`endif

endmodule

// File: tb/tb_float_gt_compare.sv
// Self-checking bench for float_gt_compare (single precision): directed vectors
// with literal expectations plus a per-cycle comparison against a value-order model.
module tb_float_gt_compare;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] float1;
  logic [31:0] float2;
  logic        out_valid;
  logic        gt;
`ifdef FLOAT_GT_UNORDERED_EN
  logic        unordered;
`endif

  int checks   = 0;
  int failures = 0;

  float_gt_compare #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .float1    (float1),
    .float2    (float2),
    .out_valid (out_valid),
`ifdef FLOAT_GT_UNORDERED_EN
    .unordered (unordered),
`endif
    .gt        (gt)
  );

  always #5 clk = ~clk;

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Map each float to a signed key on the real number line; +0 and -0 both land on 0.
  function automatic bit model_gt(input logic [31:0] a, input logic [31:0] b);
    longint ka;
    longint kb;
    if (is_nan(a) || is_nan(b)) return 1'b0;
    ka = longint'(a[30:0]);
    kb = longint'(b[30:0]);
    if (a[31]) ka = -ka;
    if (b[31]) kb = -kb;
    return ka > kb;
  endfunction

  logic m_valid;
  logic m_gt;
  logic m_unord;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_gt    <= 1'b0;
      m_unord <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_gt    <= model_gt(float1, float2);
        m_unord <= is_nan(float1) || is_nan(float2);
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every cycle.
  always @(negedge clk) begin
    check_bit("model_out_valid", out_valid, m_valid);
    check_bit("model_gt", gt, m_gt);
`ifdef FLOAT_GT_UNORDERED_EN
    check_bit("model_unordered", unordered, m_unord);
`endif
  end

  // Caller is at a negedge; result checked at the following negedge.
  task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic exp_gt);
    float1   = a;
    float2   = b;
    in_valid = 1'b1;
    check_bit({name, "_model_pin"}, model_gt(a, b), exp_gt);
    @(negedge clk);
    check_bit({name, "_valid"}, out_valid, 1'b1);
    check_bit({name, "_gt"}, gt, exp_gt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    float1   = '0;
    float2   = '0;
    repeat (2) @(negedge clk);
    check_bit("reset_valid", out_valid, 1'b0);
    check_bit("reset_gt", gt, 1'b0);
    reset = 1'b0;

    vec("pos_075_025",  32'h3F400000, 32'h3E800000, 1'b1);
    vec("neg_050_025",  32'hBF000000, 32'hBE800000, 1'b0);
    vec("pos_vs_neg",   32'h3E800000, 32'hBE800000, 1'b1);
    vec("near_pos",     32'h42906733, 32'h42906799, 1'b0);
    vec("near_neg",     32'hC2906733, 32'hC2906799, 1'b1);
    vec("zero_pm",      32'h00000000, 32'h80000000, 1'b0);
    vec("zero_mp",      32'h80000000, 32'h00000000, 1'b0);
    vec("nan_a",        32'h7FC00000, 32'hBF800000, 1'b0);
`ifdef FLOAT_GT_UNORDERED_EN
    check_bit("nan_a_unordered", unordered, 1'b1);
`endif
    vec("inf_vs_max",   32'h7F800000, 32'h7F7FFFFF, 1'b1);
    vec("nan_b",        32'h3F800000, 32'h7F800001, 1'b0);
    vec("equal_bits",   32'h3F800000, 32'h3F800000, 1'b0);
    vec("zero_vs_tiny", 32'h00000000, 32'h80000001, 1'b1);
    vec("subn_vs_zero", 32'h00000001, 32'h00000000, 1'b1);
    vec("ninf_vs_nmax", 32'hFF800000, 32'hFF7FFFFF, 1'b0);
    vec("one_vs_two",   32'h3F800000, 32'h40000000, 1'b0);

    // Hold: in_valid low with operands that would flip the result.
    vec("pre_hold", 32'h40000000, 32'h3F800000, 1'b1);
    float1   = 32'h3F800000;
    float2   = 32'h40000000;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("hold_valid", out_valid, 1'b0);
    check_bit("hold_gt", gt, 1'b1);

    // Asynchronous reset mid-stream with a pending gt=1 result.
    vec("pre_reset", 32'h40000000, 32'h3F800000, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_bit("async_reset_valid", out_valid, 1'b0);
    check_bit("async_reset_gt", gt, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      float1   = $urandom;
      float2   = (i % 4 == 0) ? {~float1[31], float1[30:0]} : $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
